mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Pipeline-side request controller sitting directly upstream of `mem_system` in the memory stage. It accepts one load/store from the pipeline, holds address and write data stable for the whole cache transaction, pulses the one-cycle `Rd`/`Wr` command, and waits for `Done`. It then returns read data and a response strobe, and stalls the pipeline meanwhile. It also rejects misaligned or malformed requests, enforces a timeout and keeps hit/miss statistics.

## Interface
- `TIMEOUT`, 64: max cycles in WAIT before the request is abandoned (1..255).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  pipeline request present.
- `req_rd`  in  1  load request.
- `req_wr`  in  1  store request.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data.
- `stall_pipe`  out  1  pipeline must hold its request/state.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  16  load data, valid with `resp_valid` for loads.
- `resp_err`  out  1  response is an error (misaligned, malformed, timeout, or memory error).
- `Addr`  out  16  to `mem_system`.
- `DataIn`  out  16  to `mem_system`.
- `Rd`  out  1  to `mem_system`.
- `Wr`  out  1  to `mem_system`.
- `DataOut`  in  16  from `mem_system`.
- `Done`  in  1  from `mem_system`.
- `CacheHit`  in  1  from `mem_system`.
- `err`  in  1  from `mem_system`.
- `hit_cnt`  out  16  saturating count of completed hits.
- `miss_cnt`  out  16  saturating count of completed misses.
- `err_sticky`  out  1  set on any error response; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, RESP (registered, 2 bits).
- Reset (`rst`=0, asynchronous): state IDLE; latched addr/data/op, `resp_rdata`, `hit_cnt`, `miss_cnt`, `err_sticky`, wait counter all 0. Outputs: `stall_pipe`=0, `resp_valid`=0, `resp_err`=0, `Rd`=`Wr`=0, `Addr`=`DataIn`=0.
- IDLE: `stall_pipe` = `req_valid` (combinational). If `req_valid`: latch `req_addr`, `req_wdata`, op.
  - If `req_rd`=`req_wr` (both or neither) or `req_addr[0]`=1: go to RESP with error flag set; no `mem_system` access.
  - Otherwise go to ISSUE.
- ISSUE: `Rd` (load) or `Wr` (store) = 1 for exactly this cycle; `Addr`/`DataIn` = latched values; `stall_pipe`=1; clear the wait counter; go to WAIT.
- WAIT: `Rd`=`Wr`=0; `Addr`/`DataIn` held; `stall_pipe`=1; the wait counter increments each cycle.
  - On `Done`=1: capture `DataOut` into `resp_rdata` (loads only; stores leave it unchanged). Increment `hit_cnt` if `CacheHit`, else `miss_cnt`; both saturate at 0xFFFF. Set the error flag if `err`. Go to RESP.
  - When the counter reaches `TIMEOUT` without `Done`: set the error flag and go to RESP.
  - `Done` in the same cycle as the timeout: treated as `Done`, with no error.
  - `err` without `Done`: recorded; the block keeps waiting.
- RESP: `resp_valid`=1, `resp_err` = error flag, `stall_pipe`=0.
  - Set `err_sticky` if the error flag is set; clear the error flag.
  - `req_valid` is ignored in this cycle. Go to IDLE.
- Reset mid-transaction: everything is abandoned immediately and no response is issued. `mem_system` shares the same reset.

## Timing
- Read or write hit: accept at cycle T (IDLE), `Rd`/`Wr` at T+1, `Done` at T+2, `resp_valid` at T+3. `stall_pipe` is high for T..T+2.
- Miss: `resp_valid` comes one cycle after `Done`, whatever the miss duration.
- Error on decode: accept at T, `resp_valid`+`resp_err` at T+1, and `Rd`/`Wr` are never asserted.
- Back-to-back throughput: at most one request per 4 cycles (hit), with the next accept possible in the cycle after RESP.
- `Addr` and `DataIn` are stable from ISSUE through the end of WAIT.

## Test plan
- Load hit: preload a line; `req_rd`, addr 0x0010. Expect `Rd` pulse at T+1, `resp_valid` at T+3, `resp_rdata` = stored word, `hit_cnt` 0→1.
- Store miss with a dirty victim: `req_wr`, addr 0x0812, data 0xBEEF. Expect `stall_pipe` held until `Done`, `resp_valid` one cycle after `Done`, `miss_cnt`+1. A following load from 0x0812 returns 0xBEEF and counts as a hit.
- Misaligned: `req_rd`, addr 0x0003. Expect `resp_valid`=`resp_err`=1 at T+1, `Rd` never asserted, `err_sticky`=1.
- Malformed: `req_rd`=`req_wr`=1. Expect the same error response and no `mem_system` command.
- Timeout: model `Done` never arriving, with `TIMEOUT`=8. Expect `resp_err` at ISSUE+9 and `err_sticky`=1. Then assert `rst`=0 mid-WAIT in a second run: all outputs return to 0 asynchronously.
- Counter saturation: force `hit_cnt` to 0xFFFE, run 3 hits. Expect `hit_cnt` to stay at 0xFFFF.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Pipeline-side request controller for mem_system: latches one load/store, issues a
// one-cycle Rd/Wr, waits for Done (or timeout), then returns a response strobe.
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall_pipe,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] Addr,
  output logic [15:0] DataIn,
  output logic        Rd,
  output logic        Wr,
  input  logic [15:0] DataOut,
  input  logic        Done,
  input  logic        CacheHit,
  input  logic        err,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic        err_sticky
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Wait counter is cleared in ISSUE, so the last WAIT cycle sees TIMEOUT-1.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        is_rd_q, is_rd_d;
  logic        err_flag_q, err_flag_d;
  logic        err_sticky_q, err_sticky_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      is_rd_q      <= 1'b0;
      err_flag_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      is_rd_q      <= is_rd_d;
      err_flag_q   <= err_flag_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    is_rd_d      = is_rd_q;
    err_flag_d   = err_flag_q;
    err_sticky_d = err_sticky_q;
    stall_pipe   = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    Rd           = 1'b0;
    Wr           = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall_pipe = req_valid;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          is_rd_d = req_rd;
          // Malformed or misaligned requests never reach mem_system.
          if ((req_rd == req_wr) || req_addr[0]) begin
            err_flag_d = 1'b1;
            state_d    = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        stall_pipe = 1'b1;
        Rd         = is_rd_q;
        Wr         = !is_rd_q;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        stall_pipe = 1'b1;
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (Done) begin
          if (is_rd_q) rdata_d = DataOut;
          if (CacheHit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
          err_flag_d = err_flag_q | err;
          state_d    = StResp;
        end else if (wait_cnt_q == WaitLast) begin
          err_flag_d = 1'b1;
          state_d    = StResp;
        end else begin
          // A memory error without Done is remembered while waiting continues.
          err_flag_d = err_flag_q | err;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_flag_q;
        if (err_flag_q) err_sticky_d = 1'b1;
        err_flag_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Addr       = addr_q;
  assign DataIn     = wdata_q;
  assign resp_rdata = rdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: a bench-side mem_system model answers commands,
// and a transaction-level reference model predicts timing, responses and statistics.
module tb_mem_req_ctrl;

  localparam int unsigned TO = 8;

  logic        clk, rst;
  logic        req_valid, req_rd, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        stall_pipe, resp_valid, resp_err;
  logic [15:0] resp_rdata, Addr, DataIn, DataOut, hit_cnt, miss_cnt;
  logic        Rd, Wr, Done, CacheHit, err, err_sticky;

  int n_vec, n_bad;

  mem_req_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_pipe(stall_pipe),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr), .DataOut(DataOut), .Done(Done),
    .CacheHit(CacheHit), .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side backing store of the memory system.
  logic [15:0] mem [logic [15:0]];

  // Observations of one transaction, cycle 0 = accept cycle.
  int          o_cmd_cyc, o_cmds, o_resp_cyc, o_stall_bad, o_addr_bad;
  logic        o_rd_seen, o_wr_seen, o_resp_err;
  logic [15:0] o_rdata;

  // Reference model state and per-transaction expectations.
  logic [15:0] m_hit, m_miss, m_rdata;
  logic        m_sticky;
  int          e_resp, e_cmds;
  logic        e_err;

  function automatic void predict(input logic rd, input logic wr, input logic [15:0] a,
                                  input int lat, input logic hit, input logic merr,
                                  input logic pre);
    e_cmds = 0;
    e_resp = 1;
    e_err  = 1'b1;
    if (rd != wr && !a[0]) begin
      e_cmds = 1;
      if (lat == 0 || lat > int'(TO)) begin
        e_resp = int'(TO) + 2;
      end else begin
        e_resp = lat + 2;
        e_err  = merr | pre;
        if (hit) m_hit = (m_hit == 16'hFFFF) ? m_hit : m_hit + 16'd1;
        else     m_miss = (m_miss == 16'hFFFF) ? m_miss : m_miss + 16'd1;
        if (rd) m_rdata = mem.exists(a) ? mem[a] : 16'h0000;
      end
    end
    m_sticky = m_sticky | e_err;
  endfunction

  // Pipeline holds its request until the response; mem_system answers lat cycles after
  // the command (lat=0: never). pre pulses err alone one cycle after the command.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input int lat, input logic hit,
                     input logic merr, input logic pre);
    int done_cyc;
    done_cyc    = -1;
    o_cmd_cyc   = -1;
    o_cmds      = 0;
    o_resp_cyc  = -1;
    o_stall_bad = 0;
    o_addr_bad  = 0;
    o_rd_seen   = 1'b0;
    o_wr_seen   = 1'b0;
    o_resp_err  = 1'b0;
    o_rdata     = 16'h0000;
    @(negedge clk);
    req_valid = 1'b1; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
    #1;
    if (stall_pipe !== 1'b1) o_stall_bad++;
    for (int c = 1; c <= 40 && o_resp_cyc < 0; c++) begin
      @(negedge clk);
      Done = 1'b0; err = 1'b0; CacheHit = 1'b0; DataOut = 16'($urandom);
      if (c == done_cyc) begin
        Done = 1'b1; CacheHit = hit; err = merr;
        if (wr && !rd) mem[a] = d;
        else DataOut = mem.exists(a) ? mem[a] : 16'h0000;
      end else if (pre && o_cmd_cyc > 0 && c == o_cmd_cyc + 1) begin
        err = 1'b1;
      end
      #1;
      if (Rd === 1'b1 || Wr === 1'b1) begin
        o_cmds++;
        o_cmd_cyc = c;
        o_rd_seen = o_rd_seen | Rd;
        o_wr_seen = o_wr_seen | Wr;
        if (lat > 0) done_cyc = c + lat;
      end
      if (resp_valid === 1'b1) begin
        o_resp_cyc = c;
        o_resp_err = resp_err;
        o_rdata    = resp_rdata;
        if (stall_pipe !== 1'b0) o_stall_bad++;
      end else begin
        if (stall_pipe !== 1'b1) o_stall_bad++;
        if (o_cmd_cyc > 0 && (Addr !== a || DataIn !== d)) o_addr_bad++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; Done = 1'b0; err = 1'b0; CacheHit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; DataOut = '0; Done = 1'b0; CacheHit = 1'b0; err = 1'b0;
    m_hit = '0; m_miss = '0; m_rdata = '0; m_sticky = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if ({stall_pipe, resp_valid, resp_err, Rd, Wr} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {stall_pipe, resp_valid, resp_err, Rd, Wr}); end
    n_vec++; if ({Addr, DataIn, resp_rdata} !== 48'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {Addr, DataIn, resp_rdata}); end
    n_vec++; if ({hit_cnt, miss_cnt, err_sticky} !== 33'h0) begin
      n_bad++; $display("FAIL reset_stats: got %h want 0", {hit_cnt, miss_cnt, err_sticky}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_hit();
    mem[16'h0010] = 16'h1234;
    predict(1'b1, 1'b0, 16'h0010, 1, 1'b1, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h5555, 1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (o_cmd_cyc !== 1 || !o_rd_seen || o_wr_seen) begin
      n_bad++; $display("FAIL load_hit_cmd: cycle %0d rd %b wr %b want 1 1 0", o_cmd_cyc, o_rd_seen, o_wr_seen); end
    n_vec++; if (o_resp_cyc !== e_resp || o_resp_err !== 1'b0) begin
      n_bad++; $display("FAIL load_hit_resp: cycle %0d err %b want %0d 0", o_resp_cyc, o_resp_err, e_resp); end
    n_vec++; if (o_rdata !== 16'h1234) begin
      n_bad++; $display("FAIL load_hit_data: got %h want 1234", o_rdata); end
    n_vec++; if (hit_cnt !== 16'd1 || o_stall_bad != 0) begin
      n_bad++; $display("FAIL load_hit_cnt: hits %0d stall_bad %0d want 1 0", hit_cnt, o_stall_bad); end
  endtask

  task automatic test_store_miss();
    predict(1'b0, 1'b1, 16'h0812, 5, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 16'h0812, 16'hBEEF, 5, 1'b0, 1'b0, 1'b0);
    n_vec++; if (o_resp_cyc !== e_resp || o_stall_bad != 0 || o_addr_bad != 0) begin
      n_bad++; $display("FAIL store_miss_timing: cycle %0d stall_bad %0d addr_bad %0d want %0d 0 0",
                        o_resp_cyc, o_stall_bad, o_addr_bad, e_resp); end
    n_vec++; if (!o_wr_seen || o_rd_seen || o_cmds != 1) begin
      n_bad++; $display("FAIL store_miss_cmd: wr %b rd %b count %0d want 1 0 1", o_wr_seen, o_rd_seen, o_cmds); end
    n_vec++; if (miss_cnt !== m_miss || o_rdata !== m_rdata) begin
      n_bad++; $display("FAIL store_miss_stats: misses %0d rdata %h want %0d %h", miss_cnt, o_rdata, m_miss, m_rdata); end
    predict(1'b1, 1'b0, 16'h0812, 1, 1'b1, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 16'h0812, 16'h0000, 1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (o_rdata !== 16'hBEEF || hit_cnt !== m_hit) begin
      n_bad++; $display("FAIL reload_after_store: data %h hits %0d want beef %0d", o_rdata, hit_cnt, m_hit); end
  endtask

  task automatic test_decode_err();
    logic [1:0]  ops [3];
    logic [15:0] adr [3];
    ops[0] = 2'b10; adr[0] = 16'h0003;
    ops[1] = 2'b11; adr[1] = 16'h0020;
    ops[2] = 2'b00; adr[2] = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      predict(ops[i][1], ops[i][0], adr[i], 1, 1'b1, 1'b0, 1'b0);
      txn(ops[i][1], ops[i][0], adr[i], 16'h0, 1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (o_resp_cyc !== 1 || o_resp_err !== 1'b1 || o_cmds != 0) begin
        n_bad++; $display("FAIL decode_err[%0d]: cycle %0d err %b cmds %0d want 1 1 0",
                          i, o_resp_cyc, o_resp_err, o_cmds); end
      n_vec++; if (err_sticky !== 1'b1) begin
        n_bad++; $display("FAIL decode_sticky[%0d]: got %b want 1", i, err_sticky); end
    end
  endtask

  task automatic test_timeout();
    predict(1'b1, 1'b0, 16'h0100, 0, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 16'h0100, 16'h0, 0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (o_resp_cyc !== 10 || o_resp_err !== 1'b1) begin
      n_bad++; $display("FAIL timeout: cycle %0d err %b want 10 1", o_resp_cyc, o_resp_err); end
    predict(1'b0, 1'b1, 16'h0102, int'(TO), 1'b0, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 16'h0102, 16'hA5A5, int'(TO), 1'b0, 1'b0, 1'b0);
    n_vec++; if (o_resp_cyc !== 10 || o_resp_err !== 1'b0 || miss_cnt !== m_miss) begin
      n_bad++; $display("FAIL done_at_timeout: cycle %0d err %b misses %0d want 10 0 %0d",
                        o_resp_cyc, o_resp_err, miss_cnt, m_miss); end
    predict(1'b1, 1'b0, 16'h0102, 3, 1'b0, 1'b0, 1'b1);
    txn(1'b1, 1'b0, 16'h0102, 16'h0, 3, 1'b0, 1'b0, 1'b1);
    n_vec++; if (o_resp_err !== 1'b1 || o_rdata !== 16'hA5A5 || o_resp_cyc !== e_resp) begin
      n_bad++; $display("FAIL err_before_done: err %b data %h cycle %0d want 1 a5a5 %0d",
                        o_resp_err, o_rdata, o_resp_cyc, e_resp); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      predict(1'b1, 1'b0, 16'h0010, 1, 1'b1, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 16'h0010, 16'h0, 1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (o_cmd_cyc !== 1 || o_resp_cyc !== 3 || hit_cnt !== m_hit) begin
        n_bad++; $display("FAIL back_to_back[%0d]: cmd %0d resp %0d hits %0d want 1 3 %0d",
                          i, o_cmd_cyc, o_resp_cyc, hit_cnt, m_hit); end
    end
  endtask

  task automatic test_random();
    logic rd, wr, hit, merr, pre;
    logic [15:0] a, d;
    int lat, kind;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      rd   = 1'($urandom);
      wr   = !rd;
      a    = 16'h0200 + 16'($urandom_range(0, 7)) * 16'd2;
      d    = 16'($urandom);
      if (kind == 0) wr = rd;
      if (kind == 1) a[0] = 1'b1;
      lat  = (kind == 2) ? 0 : int'($urandom_range(1, 6));
      hit  = (lat == 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      merr = 1'($urandom_range(0, 7) == 0);
      pre  = (lat != 1) && ($urandom_range(0, 7) == 0);
      predict(rd, wr, a, lat, hit, merr, pre);
      txn(rd, wr, a, d, lat, hit, merr, pre);
      n_vec++; if (o_resp_cyc !== e_resp || o_resp_err !== e_err || o_cmds != e_cmds) begin
        n_bad++; $display("FAIL rand[%0d]_resp: cycle %0d err %b cmds %0d want %0d %b %0d",
                          i, o_resp_cyc, o_resp_err, o_cmds, e_resp, e_err, e_cmds); end
      n_vec++; if (o_rdata !== m_rdata || hit_cnt !== m_hit || miss_cnt !== m_miss
                   || err_sticky !== m_sticky) begin
        n_bad++; $display("FAIL rand[%0d]_state: rdata %h hit %0d miss %0d sticky %b want %h %0d %0d %b",
                          i, o_rdata, hit_cnt, miss_cnt, err_sticky, m_rdata, m_hit, m_miss, m_sticky); end
      n_vec++; if (o_stall_bad != 0 || o_addr_bad != 0 || (e_cmds == 1 && o_rd_seen !== rd)) begin
        n_bad++; $display("FAIL rand[%0d]_iface: stall_bad %0d addr_bad %0d rd %b want 0 0 %b",
                          i, o_stall_bad, o_addr_bad, o_rd_seen, rd); end
    end
  endtask

  task automatic test_saturation();
    force dut.hit_cnt_q = 16'hFFFE;
    m_hit = 16'hFFFE;
    predict(1'b1, 1'b0, 16'h0010, 1, 1'b1, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0, 1, 1'b1, 1'b0, 1'b0);
    release dut.hit_cnt_q;
    for (int i = 0; i < 2; i++) begin
      predict(1'b1, 1'b0, 16'h0010, 1, 1'b1, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 16'h0010, 16'h0, 1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (hit_cnt !== m_hit) begin
        n_bad++; $display("FAIL hit_saturate[%0d]: got %h want %h", i, hit_cnt, m_hit); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b0; req_wr = 1'b1; req_addr = 16'h0812; req_wdata = 16'h7E57;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_vec++; if ({stall_pipe, resp_valid, resp_err, Rd, Wr, Addr, DataIn} !== 37'h0) begin
      n_bad++; $display("FAIL async_reset_out: got %h want 0", {stall_pipe, resp_valid, resp_err, Rd, Wr, Addr, DataIn}); end
    n_vec++; if ({resp_rdata, hit_cnt, miss_cnt, err_sticky} !== 49'h0) begin
      n_bad++; $display("FAIL async_reset_stats: got %h want 0", {resp_rdata, hit_cnt, miss_cnt, err_sticky}); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (resp_valid === 1'b1 || Rd === 1'b1 || Wr === 1'b1) seen++;
    end
    n_vec++; if (seen != 0) begin
      n_bad++; $display("FAIL reset_abandons: got %0d stray cycles want 0", seen); end
    m_hit = '0; m_miss = '0; m_rdata = '0; m_sticky = 1'b0;
    predict(1'b1, 1'b0, 16'h0010, 2, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0, 2, 1'b0, 1'b0, 1'b0);
    n_vec++; if (o_resp_cyc !== e_resp || miss_cnt !== m_miss || o_rdata !== m_rdata) begin
      n_bad++; $display("FAIL after_reset: cycle %0d misses %0d data %h want %0d %0d %h",
                        o_resp_cyc, miss_cnt, o_rdata, e_resp, m_miss, m_rdata); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_load_hit();
    test_store_miss();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
